// File: rtl/jtpang_objdma_pkg.sv
// Shared types and defaults for the Pang object-table DMA controller.
package jtpang_objdma_pkg;

   localparam int unsigned AW_DEF  = 9;
   localparam int unsigned LEN_DEF = 512;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StReq  = 3'd1,
      StWait = 3'd2,
      StCopy = 3'd3,
      StRel  = 3'd4
   } state_e;

endpackage

// File: rtl/jtpang_objdma_if.sv
// Bus bundle between the object DMA, the main CPU side and the two object RAMs.
interface jtpang_objdma_if #(
   parameter int unsigned AW = 9
);

   logic          dma_go;
   logic          busak_n;
   logic          busrq;
   logic          busy;
   logic [AW-1:0] src_addr;
   logic [7:0]    src_data;
   logic [AW-1:0] dst_addr;
   logic [7:0]    dst_din;
   logic          dst_we;

   modport master (
      input  dma_go, busak_n, src_data,
      output busrq, busy, src_addr, dst_addr, dst_din, dst_we
   );

   modport slave (
      output dma_go, busak_n, src_data,
      input  busrq, busy, src_addr, dst_addr, dst_din, dst_we
   );

endinterface

// File: rtl/jtpang_objdma.sv
// Object-table DMA: grabs the Z80 bus and copies LEN bytes from the object attribute
// RAM (one cen tick read latency) into the video object buffer.
module jtpang_objdma
   import jtpang_objdma_pkg::*;
#(
   parameter int unsigned AW  = AW_DEF,
   parameter int unsigned LEN = LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   jtpang_objdma_if.master  bus
);

   localparam logic [AW:0]   LAST     = (AW+1)'(LEN - 1);
   localparam logic [AW-1:0] SRC_LAST = AW'(LEN - 1);

   state_e        state_q, state_d;
   logic          pend_q, pend_d;
   logic          take;
   logic [AW-1:0] src_addr_q, src_addr_d;
   // Index of the next byte to be written, 0..LEN.
   logic [AW:0]   wptr_q, wptr_d;
   // Set while src_data does not yet hold the byte at wptr (start of copy, after a pause).
   logic          prime_q, prime_d;
   logic [AW-1:0] dst_addr_q, dst_addr_d;
   logic [7:0]    dst_din_q, dst_din_d;
   logic          dst_we_q, dst_we_d;
   logic          paused;

   assign paused = (state_q == StCopy) && bus.busak_n;

   // Next-state logic; everything except the pending-request flag advances on cen only.
   always_comb begin
      state_d    = state_q;
      src_addr_d = src_addr_q;
      wptr_d     = wptr_q;
      prime_d    = prime_q;
      dst_addr_d = dst_addr_q;
      dst_din_d  = dst_din_q;
      dst_we_d   = dst_we_q;
      take       = 1'b0;
      if (cen) begin
         dst_we_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pend_q) begin
                  state_d = StReq;
                  take    = 1'b1;
               end
            end
            StReq: state_d = StWait;
            StWait: begin
               if (!bus.busak_n) begin
                  state_d    = StCopy;
                  src_addr_d = '0;
                  wptr_d     = '0;
                  prime_d    = 1'b1;
               end
            end
            StCopy: begin
               if (bus.busak_n) begin
                  // Bus taken back: hold any queued write and re-present the pending byte.
                  src_addr_d = wptr_q[AW-1:0];
                  prime_d    = 1'b1;
                  dst_we_d   = dst_we_q;
               end else if (prime_q) begin
                  prime_d = 1'b0;
                  if (src_addr_q != SRC_LAST) src_addr_d = src_addr_q + AW'(1);
               end else begin
                  dst_we_d   = 1'b1;
                  dst_addr_d = wptr_q[AW-1:0];
                  dst_din_d  = bus.src_data;
                  wptr_d     = wptr_q + (AW+1)'(1);
                  if (wptr_q == LAST) begin
                     state_d    = StRel;
                     src_addr_d = '0;
                  end else if (src_addr_q != SRC_LAST) begin
                     src_addr_d = src_addr_q + AW'(1);
                  end
               end
            end
            StRel: begin
               if (pend_q) begin
                  state_d = StReq;
                  take    = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      // A go pulse on the consuming clk is kept for the next transfer.
      pend_d = (pend_q && !take) || bus.dma_go;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pend_q     <= 1'b0;
         src_addr_q <= '0;
         wptr_q     <= '0;
         prime_q    <= 1'b0;
         dst_addr_q <= '0;
         dst_din_q  <= '0;
         dst_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         src_addr_q <= src_addr_d;
         wptr_q     <= wptr_d;
         prime_q    <= prime_d;
         dst_addr_q <= dst_addr_d;
         dst_din_q  <= dst_din_d;
         dst_we_q   <= dst_we_d;
      end
   end

   // Reset masks the handshake outputs in the very clk it is asserted.
   assign bus.busrq    = !rst && (state_q inside {StReq, StWait, StCopy});
   assign bus.busy     = !rst && (state_q inside {StReq, StWait, StCopy});
   assign bus.dst_we   = !rst && cen && dst_we_q && !paused;
   assign bus.src_addr = src_addr_q;
   assign bus.dst_addr = dst_addr_q;
   assign bus.dst_din  = dst_din_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: full-size 512-byte build plus a 4-byte build.
module tb_jtpang_objdma;
   import jtpang_objdma_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cen = 1'b0;
   logic mon_clr = 1'b0;
   int   cen_div = 1;
   int   cen_cnt = 0;
   int   nchk = 0;
   int   nfail = 0;

   jtpang_objdma_if #(.AW(9)) bus ();
   jtpang_objdma_if #(.AW(2)) sbus ();

   jtpang_objdma #(.AW(9), .LEN(512)) dut (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .bus (bus)
   );

   jtpang_objdma #(.AW(2), .LEN(4)) dut_s (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .bus (sbus)
   );

   logic [7:0] src_mem [512];
   logic [7:0] dst_mem [512];
   logic [7:0] s_src   [4];
   logic [7:0] s_dst   [4];
   int         wr_cnt, ord_err, s_wr_cnt, s_ord_err;
   logic [8:0] wr_exp;
   logic [1:0] s_wr_exp;

   always #5 clk = ~clk;

   // cen is one clk in every cen_div, changed on the falling edge
   always @(negedge clk) begin
      if (cen_cnt + 1 >= cen_div) begin
         cen_cnt <= 0;
         cen     <= 1'b1;
      end else begin
         cen_cnt <= cen_cnt + 1;
         cen     <= 1'b0;
      end
   end

   // source RAMs: synchronous read, one cen tick latency
   always @(posedge clk) begin
      if (cen) begin
         bus.src_data  <= src_mem[bus.src_addr];
         sbus.src_data <= s_src[sbus.src_addr];
      end
   end

   // destination buffer and write-order monitor, big build
   always @(posedge clk) begin
      if (mon_clr) begin
         wr_cnt  <= 0;
         ord_err <= 0;
         wr_exp  <= '0;
         for (int i = 0; i < 512; i++) dst_mem[i] <= 8'(i) ^ 8'hA5;
      end else if (bus.dst_we) begin
         dst_mem[bus.dst_addr] <= bus.dst_din;
         if (bus.dst_addr != wr_exp) ord_err <= ord_err + 1;
         wr_exp <= wr_exp + 9'd1;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // destination buffer and write-order monitor, small build
   always @(posedge clk) begin
      if (mon_clr) begin
         s_wr_cnt  <= 0;
         s_ord_err <= 0;
         s_wr_exp  <= '0;
         for (int i = 0; i < 4; i++) s_dst[i] <= 8'(i) ^ 8'hA5;
      end else if (sbus.dst_we) begin
         s_dst[sbus.dst_addr] <= sbus.dst_din;
         if (sbus.dst_addr != s_wr_exp) s_ord_err <= s_ord_err + 1;
         s_wr_exp <= s_wr_exp + 2'd1;
         s_wr_cnt <= s_wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      do @(posedge clk); while (!cen);
      #1;
   endtask

   task automatic pulse_go();
      @(negedge clk);
      bus.dma_go = 1'b1;
      @(negedge clk);
      bus.dma_go = 1'b0;
   endtask

   task automatic clear_mon();
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic wait_busrq(input logic lvl, input int bound, output int n);
      n = 0;
      while (bus.busrq !== lvl && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_wr(input string tag, input int target, input int bound);
      int n = 0;
      while (wr_cnt < target && n < bound) begin
         tick();
         n++;
      end
      check(tag, wr_cnt, target);
   endtask

   task automatic check_content(input string tag);
      int bad = 0;
      for (int i = 0; i < 512; i++) begin
         logic [7:0] e;
         e = 8'(i) ^ 8'h5A;
         if (dst_mem[i] !== e) bad++;
      end
      check(tag, bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, snap, bad;
      logic [7:0] e;

      for (int i = 0; i < 512; i++) src_mem[i] = 8'(i) ^ 8'h5A;
      for (int i = 0; i < 4; i++) s_src[i] = 8'(i) ^ 8'h5A;
      bus.dma_go   = 1'b0;
      bus.busak_n  = 1'b1;
      sbus.dma_go  = 1'b0;
      sbus.busak_n = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busrq", bus.busrq, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_dst_we", bus.dst_we, 0);
      check("rst_src_addr", bus.src_addr, 0);
      check("rst_dst_addr", bus.dst_addr, 0);
      check("rst_dst_din", bus.dst_din, 0);
      check("rst_pend", dut.pend_q, 0);
      check("rst_state", 32'(dut.state_q), 32'(StIdle));
      check("rst_s_state", 32'(dut_s.state_q), 32'(StIdle));
      @(negedge clk);
      rst = 1'b0;

      // 1: plain transfer, acknowledge 3 cen after busrq
      clear_mon();
      pulse_go();
      wait_busrq(1'b1, 10, n);
      check("t1_req_lat", n, 1);
      check("t1_busy", bus.busy, 1);
      repeat (3) tick();
      bus.busak_n = 1'b0;
      tick();
      check("t1_copy_entry", 32'(dut.state_q), 32'(StCopy));
      wait_busrq(1'b0, 600, n);
      check("t1_rel_lat", n, 513);
      check("t1_busy_low", bus.busy, 0);
      bus.busak_n = 1'b1;
      tick();
      check("t1_idle", 32'(dut.state_q), 32'(StIdle));
      check("t1_writes", wr_cnt, 512);
      check("t1_order", ord_err, 0);
      check_content("t1_content");

      // 2: two go pulses during copy give exactly one more transfer
      clear_mon();
      bus.busak_n = 1'b0;
      pulse_go();
      wait_wr("t2_wait_wr", 50, 300);
      pulse_go();
      repeat (3) tick();
      pulse_go();
      wait_busrq(1'b0, 600, n);
      tick();
      check("t2_gap_busrq", bus.busrq, 1);
      check("t2_gap_state", 32'(dut.state_q), 32'(StReq));
      wait_busrq(1'b0, 700, n);
      check("t2_second_len", n, 515);
      bus.busak_n = 1'b1;
      tick();
      check("t2_writes", wr_cnt, 1024);
      check("t2_order", ord_err, 0);
      check_content("t2_content");
      repeat (5) tick();
      check("t2_no_third_busrq", bus.busrq, 0);
      check("t2_no_third_state", 32'(dut.state_q), 32'(StIdle));

      // 3: bus taken back for 10 cen at byte 100
      clear_mon();
      bus.busak_n = 1'b0;
      pulse_go();
      wait_wr("t3_wait_wr", 100, 400);
      bus.busak_n = 1'b1;
      snap = wr_cnt;
      repeat (10) tick();
      check("t3_gap_writes", wr_cnt, snap);
      check("t3_busrq_hold", bus.busrq, 1);
      check("t3_state_hold", 32'(dut.state_q), 32'(StCopy));
      bus.busak_n = 1'b0;
      wait_busrq(1'b0, 700, n);
      bus.busak_n = 1'b1;
      tick();
      check("t3_writes", wr_cnt, 512);
      check("t3_order", ord_err, 0);
      e = 8'd100 ^ 8'h5A;
      check("t3_byte100", dst_mem[100], e);
      e = 8'd101 ^ 8'h5A;
      check("t3_byte101", dst_mem[101], e);
      check_content("t3_content");

      // 4: reset in the middle of a copy
      clear_mon();
      bus.busak_n = 1'b0;
      pulse_go();
      wait_wr("t4_wait_wr", 200, 600);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t4_rst_busrq", bus.busrq, 0);
      check("t4_rst_busy", bus.busy, 0);
      check("t4_rst_dst_we", bus.dst_we, 0);
      @(negedge clk);
      rst = 1'b0;
      snap = wr_cnt;
      check("t4_rst_state", 32'(dut.state_q), 32'(StIdle));
      check("t4_rst_src_addr", bus.src_addr, 0);
      repeat (20) tick();
      check("t4_no_writes", wr_cnt, snap);
      clear_mon();
      pulse_go();
      wait_busrq(1'b1, 10, n);
      check("t4_restart_lat", n, 1);
      wait_busrq(1'b0, 700, n);
      check("t4_restart_len", n, 515);
      bus.busak_n = 1'b1;
      tick();
      check("t4_writes", wr_cnt, 512);
      check_content("t4_content");

      // 5: cen active one clk in four
      cen_div = 4;
      clear_mon();
      bus.busak_n = 1'b0;
      pulse_go();
      wait_busrq(1'b1, 10, n);
      check("t5_req_lat", (n <= 2) ? 1 : 0, 1);
      wait_busrq(1'b0, 700, n);
      check("t5_len", n, 515);
      bus.busak_n = 1'b1;
      tick();
      check("t5_writes", wr_cnt, 512);
      check("t5_order", ord_err, 0);
      check_content("t5_content");
      cen_div = 1;

      // 6: 4-byte build, full address range
      clear_mon();
      sbus.busak_n = 1'b0;
      @(negedge clk);
      sbus.dma_go = 1'b1;
      @(negedge clk);
      sbus.dma_go = 1'b0;
      n = 0;
      while (sbus.busrq !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("t6_req_lat", n, 1);
      n = 0;
      while (sbus.busrq !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("t6_len", n, 7);
      sbus.busak_n = 1'b1;
      tick();
      check("t6_writes", s_wr_cnt, 4);
      check("t6_order", s_ord_err, 0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         e = 8'(i) ^ 8'h5A;
         if (s_dst[i] !== e) bad++;
      end
      check("t6_content", bad, 0);
      check("t6_src_wrap", sbus.src_addr, 0);
      check("t6_state", 32'(dut_s.state_q), 32'(StIdle));

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
